// File: rtl/legup_jtag_st_pkg.sv
// Shared definitions for the JTAG bridge byte <-> packet codec.
// Both the packet-to-byte encoder and the byte-to-packet decoder import this
// package, so the special byte values stay consistent on both sides of the link.
//   SOP_CHAR/EOP_CHAR/CHAN_CHAR/ESC_CHAR : in-band control bytes
//   ESC_XOR                              : mask applied to the byte after ESC_CHAR
//   b2p_state_t                          : decoder FSM state
package legup_jtag_st_pkg;

   localparam logic [7:0] SOP_CHAR  = 8'h7A;
   localparam logic [7:0] EOP_CHAR  = 8'h7B;
   localparam logic [7:0] CHAN_CHAR = 8'h7C;
   localparam logic [7:0] ESC_CHAR  = 8'h7D;
   localparam logic [7:0] ESC_XOR   = 8'h20;

   typedef enum logic [1:0] {
      B2P_DATA     = 2'd0,
      B2P_ESC      = 2'd1,
      B2P_CHAN     = 2'd2,
      B2P_CHAN_ESC = 2'd3
   } b2p_state_t;

endpackage

// File: rtl/legup_st_out_reg.sv
// One-entry valid/ready output register for an Avalon-ST beat
// (data, sop, eop, channel). A new beat can be loaded in the same cycle the
// held beat is popped, so a full-rate stream passes with no bubbles.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   load_i          : upstream presents a beat this cycle (only taken when in_ready_o)
//   data_i/sop_i/eop_i/chan_i : beat fields to load
//   in_ready_o      : register can accept a beat (empty or being drained)
//   out_ready_i     : downstream ready
//   out_*_o         : registered beat presented downstream
module legup_st_out_reg (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic [7:0] data_i,
   input  logic       sop_i,
   input  logic       eop_i,
   input  logic [7:0] chan_i,
   output logic       in_ready_o,
   input  logic       out_ready_i,
   output logic       out_valid_o,
   output logic [7:0] out_data_o,
   output logic       out_sop_o,
   output logic       out_eop_o,
   output logic [7:0] out_chan_o
);

   logic       valid_q;
   logic [7:0] data_q;
   logic       sop_q;
   logic       eop_q;
   logic [7:0] chan_q;

   assign in_ready_o = !valid_q || out_ready_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         chan_q  <= 8'h00;
      end else if (in_ready_o) begin
         // Register is empty or being popped: it holds whatever arrives now.
         valid_q <= load_i;
         if (load_i) begin
            data_q <= data_i;
            sop_q  <= sop_i;
            eop_q  <= eop_i;
            chan_q <= chan_i;
         end
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_sop_o   = sop_q;
   assign out_eop_o   = eop_q;
   assign out_chan_o  = chan_q;

endmodule

// File: rtl/legup_jtag_bytes_to_packets.sv
// Decodes the escape-coded JTAG byte stream into Avalon-ST packet beats.
// Control bytes (SOP/EOP/CHAN/ESC) are consumed by the FSM and never appear as
// beats; SOP/EOP only flag the next payload byte, the channel persists until
// the next channel selection.
// Optional build macro: CHANNEL_FILTER_EN -- payload on a nonzero channel is
// consumed silently and out_channel is tied to 0.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data  : encoded byte stream
//   out_valid/out_ready/out_data/out_startofpacket/out_endofpacket/out_channel
//                              : registered packet stream
module legup_jtag_bytes_to_packets
   import legup_jtag_st_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic       in_ready,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_startofpacket,
   output logic       out_endofpacket,
   output logic [7:0] out_channel
);

   b2p_state_t state_q;
   logic       sop_q;
   logic       eop_q;
   logic [7:0] chan_q;

   logic       accept;
   logic       is_payload;
   logic [7:0] payload;
   logic       load;
   logic [7:0] beat_chan;

   assign accept = in_valid && in_ready;

   always_comb begin
      is_payload = 1'b0;
      payload    = in_data;
      case (state_q)
         B2P_DATA: is_payload = (in_data != SOP_CHAR) && (in_data != EOP_CHAR) &&
                                (in_data != CHAN_CHAR) && (in_data != ESC_CHAR);
         B2P_ESC: begin
            is_payload = 1'b1;
            payload    = in_data ^ ESC_XOR;
         end
         default: is_payload = 1'b0;
      endcase
   end

`ifdef CHANNEL_FILTER_EN
   // Only channel 0 traffic reaches the output; others are swallowed.
   assign load      = accept && is_payload && (chan_q == 8'h00);
   assign beat_chan = 8'h00;
`else
   assign load      = accept && is_payload;
   assign beat_chan = chan_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= B2P_DATA;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         chan_q  <= 8'h00;
      end else if (accept) begin
         case (state_q)
            B2P_DATA: begin
               case (in_data)
                  SOP_CHAR:  sop_q   <= 1'b1;
                  EOP_CHAR:  eop_q   <= 1'b1;
                  CHAN_CHAR: state_q <= B2P_CHAN;
                  ESC_CHAR:  state_q <= B2P_ESC;
                  default: begin
                     // Payload consumed (emitted or filtered): flags are spent.
                     sop_q <= 1'b0;
                     eop_q <= 1'b0;
                  end
               endcase
            end
            B2P_ESC: begin
               sop_q   <= 1'b0;
               eop_q   <= 1'b0;
               state_q <= B2P_DATA;
            end
            B2P_CHAN: begin
               if (in_data == ESC_CHAR) begin
                  state_q <= B2P_CHAN_ESC;
               end else begin
                  chan_q  <= in_data;
                  state_q <= B2P_DATA;
               end
            end
            default: begin
               chan_q  <= in_data ^ ESC_XOR;
               state_q <= B2P_DATA;
            end
         endcase
      end
   end

   legup_st_out_reg u_out_reg (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load),
      .data_i      (payload),
      .sop_i       (sop_q),
      .eop_i       (eop_q),
      .chan_i      (beat_chan),
      .in_ready_o  (in_ready),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_sop_o   (out_startofpacket),
      .out_eop_o   (out_endofpacket),
      .out_chan_o  (out_channel)
   );

endmodule
